branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Executes relative control-transfer instructions after decode: Jcc short/near, JMP short, JCXZ, LOOP/LOOPZ/LOOPNZ.
- Pulls displacement bytes from the prefetch byte stream, forms the condition inputs (opcode, ECX, flags) and resolves taken/not-taken internally.
- Writes back decremented ECX/CX for the LOOP family.
- On taken, issues a held redirect request to fetch; on not-taken, reports the fall-through EIP.
- Sits between decode and the fetch/register file.

Parameters:
- AW, 32, address/EIP width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  decoded branch valid (one-cycle pulse)
- ir_i  in  8  opcode; for near Jcc, the 0F-escaped second byte (80h-8Fh)
- long_i  in  1  near (0F-prefixed) Jcc form
- oper32_i  in  1  32-bit operand size; also selects 32-bit EIP wrap
- addr32_i  in  1  32-bit address size; ECX vs CX for LOOP/JCXZ
- eip_i  in  AW  EIP of first displacement byte
- ecx_i  in  32  ECX at start
- zf_i, cf_i, sf_i, vf_i, pf_i  in  1 each  flags, sampled in EVAL
- qbyte_i  in  8  prefetch queue byte
- qvalid_i  in  1  byte valid
- qready_o  out  1  byte accepted when qvalid_i & qready_o
- ecx_o  out  32  new ECX
- ecx_we_o  out  1  ECX write strobe, one cycle
- redirect_o  out  1  taken-branch redirect request
- redirect_eip_o  out  AW  branch target
- redirect_ack_i  in  1  fetch accepts redirect
- next_eip_o  out  AW  fall-through EIP, valid with done_o
- taken_o  out  1  resolution, valid with done_o
- done_o  out  1  completion pulse
- illegal_o  out  1  unsupported opcode, pulses with done_o
- busy_o  out  1  not IDLE

Behaviour:
- Reset: all outputs 0; state IDLE. Reset in any state aborts with no ECX write, no redirect, no done.
- IDLE:
  - start_i latches ir/long/oper32/addr32/eip/ecx, then moves to DISP.
  - Unsupported opcode goes straight to FIN with illegal_o and no bytes consumed.
  - Supported set: 70h-7Fh, EBh, E0h-E3h with long_i=0; 80h-8Fh with long_i=1.
  - start_i ignored while busy_o.
- Displacement length LEN: short forms 1; long forms oper32 ? 4 : 2.
- DISP:
  - qready_o=1; bytes accepted little-endian; byte counter advances only on handshake. qvalid_i gaps are tolerated.
  - After LEN bytes, goes to EVAL. qready_o drops the cycle after the last accept.
- EVAL (exactly 1 cycle):
  - Condition code = long ? {4'h7, ir[3:0]} : ir.
  - take:
    - EB always.
    - Jcc per standard x86 flag rules: O/NO, B/AE, E/NE, BE/A, S/NS, P/NP, L/GE (sf^vf), LE/G.
    - JCXZ: count==0.
    - LOOP: count!=1.
    - LOOPZ: count!=1 & zf.
    - LOOPNZ: count!=1 & !zf.
    - count is ECX if addr32, else CX.
  - LOOP family: ecx_we_o=1 and ecx_o = addr32 ? ecx-1 : {ecx[31:16], cx-1} (wraps 0 to FFFFh/FFFFFFFFh). Written regardless of take. JCXZ does not write.
  - next = eip + LEN; target = next + sign-extended disp.
  - If !oper32, next and target are truncated to 16 bits with upper bits zero.
  - take goes to REDIR; not-take goes to FIN.
- REDIR: redirect_o=1 with a stable redirect_eip_o until the cycle redirect_ack_i=1; then FIN. An ack in the first REDIR cycle is legal.
- FIN: done_o=1 for one cycle with taken_o/next_eip_o/illegal_o; then IDLE.
- Latency: short not-taken with a byte available = start + 3 cycles to done.

Decomposition:
- Shared package: opcode constants (JO..JNLE, JMPS, LOOP*, JCXZ), state enum (IDLE, DISP, EVAL, REDIR, FIN), and a disp_len function.
- One natural sub-module: branch_disp_collect, a byte-stream to 32-bit sign-extended displacement assembler with LEN input and done strobe.
- The condition logic stays inline as a combinational case.

Test Plan:
- JE short, zf=1, eip=1000h, disp FEh, ack delayed 3 cycles -> redirect_eip_o=0FFFh held 3 cycles; done_o, taken_o=1.
- LOOP, addr32=0, ecx=ABCD0001h, disp 05h -> ecx_we_o, ecx_o=ABCD0000h, taken_o=0, next_eip_o=eip+1, no redirect.
- Near JNE, oper32=1, zf=0, eip=100h, bytes 78 56 34 12 with qvalid_i low between each -> redirect_eip_o=1234577Ch, exactly 4 handshakes.
- JMPS, oper32=0, eip=FFFEh, disp 10h -> redirect_eip_o=0000000Fh (16-bit wrap).
- rst_i asserted in REDIR -> next cycle redirect_o=0, busy_o=0, no done_o, no ecx_we_o.
- start_i with ir=90h -> done_o & illegal_o one cycle after start; qready_o never asserted.

Source files
------------

// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the relative branch sequencer: opcode constants,
// sequencer states and displacement-length / opcode-support helpers.
package branch_sequencer_pkg;

  localparam logic [7:0] OP_JO     = 8'h70;
  localparam logic [7:0] OP_JNO    = 8'h71;
  localparam logic [7:0] OP_JB     = 8'h72;
  localparam logic [7:0] OP_JAE    = 8'h73;
  localparam logic [7:0] OP_JE     = 8'h74;
  localparam logic [7:0] OP_JNE    = 8'h75;
  localparam logic [7:0] OP_JBE    = 8'h76;
  localparam logic [7:0] OP_JA     = 8'h77;
  localparam logic [7:0] OP_JS     = 8'h78;
  localparam logic [7:0] OP_JNS    = 8'h79;
  localparam logic [7:0] OP_JP     = 8'h7A;
  localparam logic [7:0] OP_JNP    = 8'h7B;
  localparam logic [7:0] OP_JL     = 8'h7C;
  localparam logic [7:0] OP_JGE    = 8'h7D;
  localparam logic [7:0] OP_JLE    = 8'h7E;
  localparam logic [7:0] OP_JNLE   = 8'h7F;
  localparam logic [7:0] OP_LOOPNZ = 8'hE0;
  localparam logic [7:0] OP_LOOPZ  = 8'hE1;
  localparam logic [7:0] OP_LOOP   = 8'hE2;
  localparam logic [7:0] OP_JCXZ   = 8'hE3;
  localparam logic [7:0] OP_JMPS   = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    DISP,
    EVAL,
    REDIR,
    FIN
  } state_e;

  function automatic logic [2:0] disp_len(input logic long_form, input logic oper32);
    if (!long_form) return 3'd1;
    return oper32 ? 3'd4 : 3'd2;
  endfunction

  function automatic logic is_supported(input logic [7:0] ir, input logic long_form);
    if (long_form) return ir[7:4] == 4'h8;
    return (ir[7:4] == 4'h7) || (ir == OP_JMPS) || (ir[7:2] == 6'b111000);
  endfunction

endpackage

// File: rtl/branch_disp_collect.sv
// Assembles a 1/2/4-byte little-endian displacement from the prefetch byte
// stream and presents it sign-extended to 32 bits.
module branch_disp_collect
  import branch_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [2:0]  len_i,
  input  logic [7:0]  qbyte_i,
  input  logic        qvalid_i,
  output logic        qready_o,
  output logic [31:0] disp_o,
  output logic        done_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] raw_q, raw_d;
  logic        accept;

  assign qready_o = en_i;
  assign accept   = en_i & qvalid_i;
  assign done_o   = accept && ({1'b0, cnt_q} == (len_i - 3'd1));

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    raw_d = raw_q;
    if (clear_i) begin
      cnt_d = '0;
      raw_d = '0;
    end else if (accept) begin
      raw_d[8*cnt_q +: 8] = qbyte_i;
      cnt_d               = cnt_q + 2'd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      raw_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      raw_q <= raw_d;
    end
  end

  always_comb begin
    case (len_i)
      3'd1:    disp_o = {{24{raw_q[7]}}, raw_q[7:0]};
      3'd2:    disp_o = {{16{raw_q[15]}}, raw_q[15:0]};
      default: disp_o = raw_q;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Relative control-transfer sequencer: collects the displacement, resolves the
// condition, writes back the LOOP counter and redirects fetch on taken branches.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [7:0]    ir_i,
  input  logic          long_i,
  input  logic          oper32_i,
  input  logic          addr32_i,
  input  logic [AW-1:0] eip_i,
  input  logic [31:0]   ecx_i,
  input  logic          zf_i,
  input  logic          cf_i,
  input  logic          sf_i,
  input  logic          vf_i,
  input  logic          pf_i,
  input  logic [7:0]    qbyte_i,
  input  logic          qvalid_i,
  output logic          qready_o,
  output logic [31:0]   ecx_o,
  output logic          ecx_we_o,
  output logic          redirect_o,
  output logic [AW-1:0] redirect_eip_o,
  input  logic          redirect_ack_i,
  output logic [AW-1:0] next_eip_o,
  output logic          taken_o,
  output logic          done_o,
  output logic          illegal_o,
  output logic          busy_o
);

  localparam logic [AW-1:0] MASK16 = {{(AW-16){1'b0}}, 16'hFFFF};

  state_e        state_q, state_d;
  logic [7:0]    ir_q;
  logic          long_q, oper32_q, addr32_q;
  logic [AW-1:0] eip_q, next_q, target_q;
  logic [31:0]   ecx_q;
  logic          taken_q, illegal_q;

  logic [2:0]    len;
  logic [31:0]   disp;
  logic          disp_done;
  logic [7:0]    cc;
  logic [31:0]   count;
  logic          take;
  logic          is_loop;
  logic [AW-1:0] next_eip, target_eip;
  logic [31:0]   ecx_dec;

  assign len = disp_len(long_q, oper32_q);

  branch_disp_collect u_disp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q == IDLE && start_i),
    .en_i     (state_q == DISP),
    .len_i    (len),
    .qbyte_i  (qbyte_i),
    .qvalid_i (qvalid_i),
    .qready_o (qready_o),
    .disp_o   (disp),
    .done_o   (disp_done)
  );

  // Near Jcc (0F 8x) shares the short 7x condition encoding.
  always_comb begin
    cc    = long_q ? {4'h7, ir_q[3:0]} : ir_q;
    count = addr32_q ? ecx_q : {16'h0, ecx_q[15:0]};
    take  = 1'b0;
    if (cc[7:4] == 4'h7) begin
      case (cc[3:1])
        3'd0: take = vf_i;
        3'd1: take = cf_i;
        3'd2: take = zf_i;
        3'd3: take = cf_i | zf_i;
        3'd4: take = sf_i;
        3'd5: take = pf_i;
        3'd6: take = sf_i ^ vf_i;
        default: take = zf_i | (sf_i ^ vf_i);
      endcase
      take = take ^ cc[0];
    end else begin
      case (cc)
        OP_JMPS:   take = 1'b1;
        OP_JCXZ:   take = (count == 32'd0);
        OP_LOOP:   take = (count != 32'd1);
        OP_LOOPZ:  take = (count != 32'd1) & zf_i;
        OP_LOOPNZ: take = (count != 32'd1) & ~zf_i;
        default:   take = 1'b0;
      endcase
    end
  end

  always_comb begin
    is_loop    = !long_q && (ir_q == OP_LOOP || ir_q == OP_LOOPZ || ir_q == OP_LOOPNZ);
    ecx_dec    = addr32_q ? (ecx_q - 32'd1) : {ecx_q[31:16], ecx_q[15:0] - 16'd1};
    next_eip   = eip_q + AW'(len);
    target_eip = next_eip + AW'($signed(disp));
    if (!oper32_q) begin
      next_eip   = next_eip & MASK16;
      target_eip = target_eip & MASK16;
    end
  end

  always_comb begin
    state_d    = state_q;
    ecx_we_o   = 1'b0;
    redirect_o = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      IDLE:    if (start_i) state_d = is_supported(ir_i, long_i) ? DISP : FIN;
      DISP:    if (disp_done) state_d = EVAL;
      EVAL: begin
        ecx_we_o = is_loop;
        state_d  = take ? REDIR : FIN;
      end
      REDIR: begin
        redirect_o = 1'b1;
        if (redirect_ack_i) state_d = FIN;
      end
      FIN: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o         = (state_q != IDLE);
  assign ecx_o          = ecx_we_o ? ecx_dec : 32'd0;
  assign redirect_eip_o = redirect_o ? target_q : '0;
  assign next_eip_o     = done_o ? next_q : '0;
  assign taken_o        = done_o & taken_q;
  assign illegal_o      = done_o & illegal_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      long_q    <= 1'b0;
      oper32_q  <= 1'b0;
      addr32_q  <= 1'b0;
      eip_q     <= '0;
      ecx_q     <= '0;
      next_q    <= '0;
      target_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        ir_q      <= ir_i;
        long_q    <= long_i;
        oper32_q  <= oper32_i;
        addr32_q  <= addr32_i;
        eip_q     <= eip_i;
        ecx_q     <= ecx_i;
        taken_q   <= 1'b0;
        illegal_q <= !is_supported(ir_i, long_i);
      end
      if (state_q == EVAL) begin
        taken_q  <= take;
        next_q   <= next_eip;
        target_q <= target_eip;
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed vector table, reset-abort
// sequence and randomized transactions against an instruction-level model.
module tb_branch_sequencer;

  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i, long_i, oper32_i, addr32_i;
  logic          zf_i, cf_i, sf_i, vf_i, pf_i, qvalid_i, redirect_ack_i;
  logic [7:0]    ir_i, qbyte_i;
  logic [AW-1:0] eip_i;
  logic [31:0]   ecx_i;
  logic          qready_o, ecx_we_o, redirect_o, taken_o, done_o, illegal_o, busy_o;
  logic [31:0]   ecx_o;
  logic [AW-1:0] redirect_eip_o, next_eip_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  branch_sequencer #(.AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ir_i(ir_i), .long_i(long_i),
    .oper32_i(oper32_i), .addr32_i(addr32_i), .eip_i(eip_i), .ecx_i(ecx_i),
    .zf_i(zf_i), .cf_i(cf_i), .sf_i(sf_i), .vf_i(vf_i), .pf_i(pf_i),
    .qbyte_i(qbyte_i), .qvalid_i(qvalid_i), .qready_o(qready_o),
    .ecx_o(ecx_o), .ecx_we_o(ecx_we_o), .redirect_o(redirect_o),
    .redirect_eip_o(redirect_eip_o), .redirect_ack_i(redirect_ack_i),
    .next_eip_o(next_eip_o), .taken_o(taken_o), .done_o(done_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Flags packed as {zf, cf, sf, vf, pf}.
  typedef struct {
    logic [7:0]  ir;
    logic        lng, o32, a32;
    logic [31:0] eip, ecx;
    logic [4:0]  fl;
    logic [31:0] disp;
    int          gap, ack_dly;
    logic        ill, taken;
    logic [31:0] nxt, tgt;
    logic        we;
    logic [31:0] ecx_new;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] ir, input logic lng, o32, a32,
                              input logic [31:0] eip, ecx, input logic [4:0] fl,
                              input logic [31:0] disp, input int gap, ack_dly,
                              input logic ill, taken, input logic [31:0] nxt, tgt,
                              input logic we, input logic [31:0] ecx_new, input int lat);
    vec_t v;
    v.ir = ir; v.lng = lng; v.o32 = o32; v.a32 = a32; v.eip = eip; v.ecx = ecx;
    v.fl = fl; v.disp = disp; v.gap = gap; v.ack_dly = ack_dly; v.ill = ill;
    v.taken = taken; v.nxt = nxt; v.tgt = tgt; v.we = we; v.ecx_new = ecx_new; v.lat = lat;
    return v;
  endfunction

  // Instruction-level reference: x86 semantics of each mnemonic, one at a time.
  function automatic vec_t model(input vec_t v);
    vec_t        r = v;
    logic        z, c, s, o, p, legal;
    logic [7:0]  op;
    longint      cnt;
    int          len;
    logic [31:0] d, nx, tg;
    {z, c, s, o, p} = v.fl;
    r.ill = 0; r.taken = 0; r.we = 0; r.ecx_new = 0; r.nxt = 0; r.tgt = 0; r.lat = 0;
    if (v.lng) legal = (v.ir >= 8'h80 && v.ir <= 8'h8F);
    else       legal = (v.ir >= 8'h70 && v.ir <= 8'h7F) || (v.ir >= 8'hE0 && v.ir <= 8'hE3) || v.ir == 8'hEB;
    if (!legal) begin
      r.ill = 1; r.lat = 1;
      return r;
    end
    op  = v.lng ? v.ir - 8'h10 : v.ir;
    cnt = v.a32 ? longint'(v.ecx) : longint'(v.ecx & 32'hFFFF);
    case (op)
      8'h70: r.taken = o;               8'h71: r.taken = !o;
      8'h72: r.taken = c;               8'h73: r.taken = !c;
      8'h74: r.taken = z;               8'h75: r.taken = !z;
      8'h76: r.taken = c || z;          8'h77: r.taken = !c && !z;
      8'h78: r.taken = s;               8'h79: r.taken = !s;
      8'h7A: r.taken = p;               8'h7B: r.taken = !p;
      8'h7C: r.taken = (s != o);        8'h7D: r.taken = (s == o);
      8'h7E: r.taken = z || (s != o);   8'h7F: r.taken = !z && (s == o);
      8'hE0: r.taken = (cnt != 1) && !z;
      8'hE1: r.taken = (cnt != 1) && z;
      8'hE2: r.taken = (cnt != 1);
      8'hE3: r.taken = (cnt == 0);
      default: r.taken = 1;
    endcase
    if (op >= 8'hE0 && op <= 8'hE2) begin
      r.we = 1;
      r.ecx_new = v.a32 ? v.ecx - 32'd1 : (v.ecx & 32'hFFFF0000) | ((v.ecx - 32'd1) & 32'hFFFF);
    end
    len = !v.lng ? 1 : (v.o32 ? 4 : 2);
    d   = (len == 1) ? 32'($signed(v.disp[7:0])) :
          (len == 2) ? 32'($signed(v.disp[15:0])) : v.disp;
    nx  = v.eip + 32'(len);
    tg  = nx + d;
    if (!v.o32) begin
      nx = nx & 32'hFFFF;
      tg = tg & 32'hFFFF;
    end
    r.nxt = nx;
    r.tgt = r.taken ? tg : 32'd0;
    r.lat = (!r.taken && len == 1 && v.gap == 0) ? 3 : 0;
    return r;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int          bi = 0, gcnt = 0, hs = 0, rcnt = 0, wecnt = 0, cyc = 0, lat = -1;
    int          len = v.lng ? (v.o32 ? 4 : 2) : 1;
    logic [31:0] rfirst = '0, wval = '0, d_next = '0;
    logic        rstable = 1, got_done = 0, d_taken = 0, d_ill = 0;
    start_i = 1; ir_i = v.ir; long_i = v.lng; oper32_i = v.o32; addr32_i = v.a32;
    eip_i = v.eip; ecx_i = v.ecx; {zf_i, cf_i, sf_i, vf_i, pf_i} = v.fl;
    while (!got_done && cyc < 100) begin
      if (cyc > 0) begin
        if (busy_o && !done_o) begin
          // Spurious starts with scrambled fields must be ignored while busy.
          start_i = 1; ir_i = ~v.ir; long_i = ~v.lng; oper32_i = ~v.o32;
          addr32_i = ~v.a32; eip_i = $urandom; ecx_i = $urandom;
        end else begin
          start_i = 0;
        end
      end
      if (qready_o) begin
        if (gcnt < v.gap) begin
          qvalid_i = 0; gcnt++;
        end else begin
          qvalid_i = 1;
          qbyte_i  = 8'(v.disp >> (8 * (bi % 4)));
          hs++; bi++; gcnt = 0;
        end
      end else begin
        qvalid_i = 1'($urandom_range(0, 1));
        qbyte_i  = 8'($urandom);
      end
      redirect_ack_i = 0;
      if (redirect_o) begin
        rcnt++;
        if (rcnt == 1) rfirst = redirect_eip_o;
        else if (redirect_eip_o !== rfirst) rstable = 0;
        if (rcnt >= v.ack_dly) redirect_ack_i = 1;
      end
      if (ecx_we_o) begin
        wecnt++; wval = ecx_o;
      end
      if (done_o) begin
        got_done = 1; d_taken = taken_o; d_next = next_eip_o; d_ill = illegal_o; lat = cyc;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    start_i = 0; qvalid_i = 0; redirect_ack_i = 0;
    check($sformatf("%s done", tag), 32'(got_done), 32'd1);
    check($sformatf("%s illegal", tag), 32'(d_ill), 32'(v.ill));
    check($sformatf("%s taken", tag), 32'(d_taken), 32'(v.taken));
    check($sformatf("%s handshakes", tag), 32'(hs), v.ill ? 32'd0 : 32'(len));
    check($sformatf("%s redirect_cycles", tag), 32'(rcnt), v.taken ? 32'(v.ack_dly) : 32'd0);
    check($sformatf("%s ecx_we_cycles", tag), 32'(wecnt), 32'(v.we));
    if (!v.ill) check($sformatf("%s next_eip", tag), d_next, v.nxt);
    if (v.taken) begin
      check($sformatf("%s redirect_eip", tag), rfirst, v.tgt);
      check($sformatf("%s redirect_stable", tag), 32'(rstable), 32'd1);
    end
    if (v.we) check($sformatf("%s ecx_o", tag), wval, v.ecx_new);
    if (v.lat != 0) check($sformatf("%s latency", tag), 32'(lat), 32'(v.lat));
  endtask

  vec_t tbl[12];

  initial begin
    vec_t v;
    int   hung;
    logic seen;

    tbl[0]  = mk(8'h74, 0, 1, 1, 32'h1000, 0, 5'b10000, 32'hFE, 0, 3, 0, 1, 32'h1001, 32'h0FFF, 0, 0, 0);
    tbl[1]  = mk(8'hE2, 0, 1, 0, 32'h2000, 32'hABCD0001, 5'b00000, 32'h05, 0, 1, 0, 0, 32'h2001, 0, 1, 32'hABCD0000, 3);
    tbl[2]  = mk(8'h85, 1, 1, 1, 32'h0100, 0, 5'b00000, 32'h12345678, 1, 1, 0, 1, 32'h104, 32'h1234577C, 0, 0, 0);
    tbl[3]  = mk(8'hEB, 0, 0, 1, 32'hFFFE, 0, 5'b00000, 32'h10, 0, 2, 0, 1, 32'hFFFF, 32'h000F, 0, 0, 0);
    tbl[4]  = mk(8'h90, 0, 1, 1, 32'h0, 0, 5'b00000, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(8'hE3, 0, 1, 0, 32'h3000, 32'hFFFF0000, 5'b00000, 32'h80, 0, 1, 0, 1, 32'h3001, 32'h2F81, 0, 0, 0);
    tbl[6]  = mk(8'hE2, 0, 1, 1, 32'h4000, 32'h0, 5'b00000, 32'h10, 0, 1, 0, 1, 32'h4001, 32'h4011, 1, 32'hFFFFFFFF, 0);
    tbl[7]  = mk(8'hE1, 0, 1, 0, 32'h4100, 32'h5, 5'b00000, 32'h20, 0, 1, 0, 0, 32'h4101, 0, 1, 32'h4, 3);
    tbl[8]  = mk(8'h8C, 1, 0, 1, 32'h0010, 0, 5'b00100, 32'h0000FFF0, 0, 1, 0, 1, 32'h12, 32'h2, 0, 0, 0);
    tbl[9]  = mk(8'hE0, 0, 1, 0, 32'h0500, 32'h12340000, 5'b00000, 32'h02, 0, 1, 0, 1, 32'h501, 32'h503, 1, 32'h1234FFFF, 0);
    tbl[10] = mk(8'h76, 0, 1, 1, 32'h0010, 0, 5'b00000, 32'h55, 0, 1, 0, 0, 32'h11, 0, 0, 0, 3);
    tbl[11] = mk(8'h70, 1, 1, 1, 32'h0020, 0, 5'b00000, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0, 1);

    rst_i = 1; start_i = 0; ir_i = 0; long_i = 0; oper32_i = 0; addr32_i = 0;
    eip_i = 0; ecx_i = 0; {zf_i, cf_i, sf_i, vf_i, pf_i} = '0;
    qbyte_i = 0; qvalid_i = 0; redirect_ack_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset busy", 32'(busy_o), 0);
    check("reset done", 32'(done_o), 0);
    check("reset redirect", 32'(redirect_o), 0);
    check("reset qready", 32'(qready_o), 0);
    check("reset ecx_we", 32'(ecx_we_o), 0);
    check("reset outputs", {ecx_o[7:0], redirect_eip_o[7:0], next_eip_o[7:0],
                            5'b0, taken_o, illegal_o, 1'b0}, 0);
    rst_i = 0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Reset while a redirect is pending must abort without completing.
    start_i = 1; ir_i = 8'hEB; long_i = 0; oper32_i = 1; addr32_i = 1; eip_i = 32'h2000;
    @(posedge clk_i); #1;
    start_i = 0; qvalid_i = 1; qbyte_i = 8'h04;
    hung = 0;
    while (!redirect_o && hung < 20) begin
      @(posedge clk_i); #1;
      hung++;
    end
    qvalid_i = 0;
    check("abort reached_redirect", 32'(redirect_o), 1);
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0;
    check("abort redirect", 32'(redirect_o), 0);
    check("abort busy", 32'(busy_o), 0);
    seen = 0;
    repeat (5) begin
      if (done_o || ecx_we_o) seen = 1;
      @(posedge clk_i); #1;
    end
    check("abort no_done_no_we", 32'(seen), 0);

    for (int n = 0; n < 250; n++) begin
      logic [7:0]  ir;
      logic        lng;
      logic [31:0] ecx;
      int          sel = $urandom_range(0, 9);
      lng = 0;
      case (sel)
        0, 1, 2, 3, 4: ir = 8'h70 + 8'($urandom_range(0, 15));
        5:       begin ir = 8'h80 + 8'($urandom_range(0, 15)); lng = 1; end
        6:       ir = 8'hEB;
        7, 8:    ir = 8'hE0 + 8'($urandom_range(0, 3));
        default: begin ir = 8'($urandom); lng = 1'($urandom_range(0, 1)); end
      endcase
      case ($urandom_range(0, 5))
        0: ecx = 32'h0;
        1: ecx = 32'h1;
        2: ecx = 32'h00010000;
        3: ecx = 32'h00010001;
        4: ecx = 32'h2;
        default: ecx = $urandom;
      endcase
      v = mk(ir, lng, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, ecx,
             5'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(1, 3),
             0, 0, 0, 0, 0, 0, 0);
      v = model(v);
      run_vec($sformatf("rnd%0d", n), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
